// File: rtl/mask_centroid.sv
// mask_centroid: per-frame mask blob count, bounding box and centroid via a sequential divider
module mask_centroid #(
  parameter int WIDTH = 320,
  parameter int HEIGHT = 240,
  parameter int MIN_COUNT = 64
)(
  input  logic        clk,
  input  logic        reset,
  input  logic        mask_bit,
  input  logic        mask_valid,
  input  logic [10:0] hcount,
  input  logic [9:0]  vcount,
  output logic [10:0] centroid_x,
  output logic [9:0]  centroid_y,
  output logic [16:0] pixel_count,
  output logic [10:0] x_min,
  output logic [10:0] x_max,
  output logic [9:0]  y_min,
  output logic [9:0]  y_max,
  output logic        found,
  output logic        result_valid,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, DIV_X, DIV_Y, DONE} state_t;
  state_t state;
  logic [16:0] cnt, s_cnt, rem, n_cnt, dv, nrem;
  logic [24:0] sx, n_sx;
  logic [23:0] sy, n_sy, s_sy;
  logic [10:0] xmn, xmx, s_xmn, s_xmx, n_xmn, n_xmx, dq, qx, nq;
  logic [9:0]  ymn, ymx, s_ymn, s_ymx, n_ymn, n_ymx, q;
  logic [17:0] t;
  logic [3:0]  k;
  logic        in_frame, hit, eof, ge, zero;
  // Next running totals, frame-end detect and one restoring-divide step
  always_comb begin
    in_frame = mask_valid && hcount < 11'(WIDTH) && vcount < 10'(HEIGHT);
    hit = in_frame && mask_bit;
    eof = in_frame && hcount == 11'(WIDTH - 1) && vcount == 10'(HEIGHT - 1);
    n_cnt = cnt + {16'd0, hit};
    n_sx = hit ? sx + {14'd0, hcount} : sx;
    n_sy = hit ? sy + {14'd0, vcount} : sy;
    n_xmn = hit && hcount < xmn ? hcount : xmn;
    n_xmx = hit && hcount > xmx ? hcount : xmx;
    n_ymn = hit && vcount < ymn ? vcount : ymn;
    n_ymx = hit && vcount > ymx ? vcount : ymx;
    dv = s_cnt == 17'd0 ? 17'd1 : s_cnt;
    t = {rem, dq[10]};
    ge = t >= {1'b0, dv};
    nrem = ge ? 17'(t - {1'b0, dv}) : t[16:0];
    nq = {q, ge};
    zero = s_cnt == 17'd0;
  end
  // Accumulation, frame snapshot, divider sequencing and registered result bundle
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      sx <= '0;
      sy <= '0;
      xmn <= '1;
      xmx <= '0;
      ymn <= '1;
      ymx <= '0;
      s_cnt <= '0;
      s_sy <= '0;
      s_xmn <= '0;
      s_xmx <= '0;
      s_ymn <= '0;
      s_ymx <= '0;
      rem <= '0;
      dq <= '0;
      q <= '0;
      qx <= '0;
      k <= '0;
      centroid_x <= '0;
      centroid_y <= '0;
      pixel_count <= '0;
      x_min <= '0;
      x_max <= '0;
      y_min <= '0;
      y_max <= '0;
      found <= 1'b0;
      result_valid <= 1'b0;
      busy <= 1'b0;
    end else begin
      result_valid <= 1'b0;
      cnt <= eof ? '0 : n_cnt;
      sx <= eof ? '0 : n_sx;
      sy <= eof ? '0 : n_sy;
      xmn <= eof ? '1 : n_xmn;
      xmx <= eof ? '0 : n_xmx;
      ymn <= eof ? '1 : n_ymn;
      ymx <= eof ? '0 : n_ymx;
      if (state == DIV_X || state == DIV_Y) begin
        rem <= nrem;
        dq <= {dq[9:0], 1'b0};
        q <= nq[9:0];
        k <= k + 4'd1;
      end
      case (state)
        IDLE: if (eof) begin
          s_cnt <= n_cnt;
          s_sy <= n_sy;
          s_xmn <= n_xmn;
          s_xmx <= n_xmx;
          s_ymn <= n_ymn;
          s_ymx <= n_ymx;
          rem <= {3'd0, n_sx[24:11]};
          dq <= n_sx[10:0];
          q <= '0;
          k <= '0;
          busy <= 1'b1;
          state <= DIV_X;
        end
        DIV_X: if (k == 4'd10) begin
          qx <= nq;
          rem <= {3'd0, s_sy[23:10]};
          dq <= {s_sy[9:0], 1'b0};
          q <= '0;
          k <= '0;
          state <= DIV_Y;
        end
        DIV_Y: if (k == 4'd9) state <= DONE;
        default: begin
          centroid_x <= qx;
          centroid_y <= q;
          pixel_count <= s_cnt;
          x_min <= zero ? '0 : s_xmn;
          x_max <= zero ? '0 : s_xmx;
          y_min <= zero ? '0 : s_ymn;
          y_max <= zero ? '0 : s_ymx;
          found <= s_cnt >= 17'(MIN_COUNT);
          result_valid <= 1'b1;
          busy <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mask_centroid.sv
// tb_mask_centroid: randomized scoreboard bench against a pixel-list reference model
module tb_mask_centroid;
  logic clk = 0, reset = 1, mask_bit = 0, mask_valid = 0;
  logic [10:0] hcount = 0;
  logic [9:0] vcount = 0;
  logic [10:0] centroid_x, x_min, x_max;
  logic [9:0] centroid_y, y_min, y_max;
  logic [16:0] pixel_count;
  logic found, result_valid, busy;

  mask_centroid dut (
    .clk(clk), .reset(reset), .mask_bit(mask_bit), .mask_valid(mask_valid),
    .hcount(hcount), .vcount(vcount), .centroid_x(centroid_x), .centroid_y(centroid_y),
    .pixel_count(pixel_count), .x_min(x_min), .x_max(x_max), .y_min(y_min), .y_max(y_max),
    .found(found), .result_valid(result_valid), .busy(busy)
  );

  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {int cx, cy, cnt, xmn, xmx, ymn, ymx, fnd, at;} exp_t;
  exp_t sbq[$];
  exp_t me;
  int px[$], py[$];
  int errors = 0, checks = 0, last_acc = -1000;

  task automatic chk(string name, int act, int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Reference: statistics of the list of green pixels seen this frame
  task automatic frame_end();
    exp_t e;
    int n = px.size(), sx = 0, sy = 0;
    e.xmn = 0; e.xmx = 0; e.ymn = 0; e.ymx = 0;
    if (n > 0) begin
      e.xmn = px[0]; e.xmx = px[0]; e.ymn = py[0]; e.ymx = py[0];
    end
    for (int i = 0; i < n; i++) begin
      sx += px[i]; sy += py[i];
      if (px[i] < e.xmn) e.xmn = px[i];
      if (px[i] > e.xmx) e.xmx = px[i];
      if (py[i] < e.ymn) e.ymn = py[i];
      if (py[i] > e.ymx) e.ymx = py[i];
    end
    e.cnt = n;
    e.cx = n > 0 ? sx / n : 0;
    e.cy = n > 0 ? sy / n : 0;
    e.fnd = n >= 64 ? 1 : 0;
    e.at = cyc + 22;
    if (cyc >= last_acc + 23) begin
      sbq.push_back(e);
      last_acc = cyc;
      chk("busy_after_frame_end", busy, 1);
    end
    px.delete();
    py.delete();
  endtask

  task automatic pix(int x, int y, bit m, bit v);
    mask_bit = m; mask_valid = v; hcount = 11'(x); vcount = 10'(y);
    @(posedge clk); #1;
    if (v && x < 320 && y < 240 && m) begin
      px.push_back(x); py.push_back(y);
    end
    if (v && x == 319 && y == 239) frame_end();
    mask_valid = 0; mask_bit = 0;
  endtask

  task automatic idle(int n);
    repeat (n) pix(0, 0, 0, 0);
  endtask

  task automatic rect(int x0, int y0, int w, int h);
    for (int y = y0; y < y0 + h; y++)
      for (int x = x0; x < x0 + w; x++) pix(x, y, 1, 1);
  endtask

  task automatic noise(int n);
    for (int i = 0; i < n; i++) begin
      case ($urandom_range(0, 2))
        0: pix($urandom_range(320, 2047), $urandom_range(0, 1023), 1, 1);
        1: pix($urandom_range(0, 319), $urandom_range(240, 1023), 1, 1);
        default: pix($urandom_range(0, 319), $urandom_range(0, 239), 1, 0);
      endcase
    end
  endtask

  task automatic rand_frame();
    rect($urandom_range(0, 300), $urandom_range(0, 225), $urandom_range(1, 16), $urandom_range(1, 12));
    for (int i = $urandom_range(0, 20); i > 0; i--) pix($urandom_range(0, 318), $urandom_range(0, 238), 1, 1);
    noise($urandom_range(0, 10));
    pix(319, 239, 1'($urandom_range(0, 1)), 1);
  endtask

  // Monitor: pop and compare whenever the DUT presents a result
  always @(negedge clk) begin
    if (!reset && result_valid) begin
      if (sbq.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_result_valid: got 1 expected 0 (cycle %0d)", cyc);
      end else begin
        me = sbq.pop_front();
        chk("latency", cyc, me.at);
        chk("centroid_x", int'(centroid_x), me.cx);
        chk("centroid_y", int'(centroid_y), me.cy);
        chk("pixel_count", int'(pixel_count), me.cnt);
        chk("x_min", int'(x_min), me.xmn);
        chk("x_max", int'(x_max), me.xmx);
        chk("y_min", int'(y_min), me.ymn);
        chk("y_max", int'(y_max), me.ymx);
        chk("found", int'(found), me.fnd);
        chk("busy_at_result", int'(busy), 0);
      end
    end
  end

  task automatic chk_zero(string tag);
    chk({tag, "_bundle"}, int'(centroid_x) + int'(centroid_y) + int'(pixel_count) + int'(x_min)
        + int'(x_max) + int'(y_min) + int'(y_max) + int'(found), 0);
    chk({tag, "_result_valid"}, int'(result_valid), 0);
    chk({tag, "_busy"}, int'(busy), 0);
  endtask

  initial begin
    int w;
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset");
    reset = 0;
    idle(2);
    // uniform 10x10 block with interleaved ignored pixels
    for (int y = 50; y < 60; y++) begin
      for (int x = 100; x < 110; x++) pix(x, y, 1, 1);
      pix(400, y, 1, 1);
      pix(105, y, 1, 0);
    end
    pix(319, 239, 0, 1);
    idle(25);
    // empty frame
    noise(5);
    pix(319, 239, 0, 1);
    idle(25);
    // threshold edge: 63 then 64 pixels
    rect(0, 5, 63, 1);
    pix(319, 239, 0, 1);
    idle(3);
    rect(0, 7, 64, 1);
    pix(319, 239, 0, 1);
    idle(25);
    // non-integer centroid
    pix(0, 0, 1, 1); pix(1, 0, 1, 1); pix(1, 1, 1, 1);
    pix(319, 239, 0, 1);
    idle(25);
    // single-pixel blob that is the frame-end pixel itself
    pix(319, 239, 1, 1);
    idle(25);
    // back-to-back frames with no gap
    rand_frame();
    rect(200, 100, 5, 6);
    noise(4);
    pix(319, 239, 0, 1);
    // frame end while busy is discarded, next frame unaffected
    pix(3, 3, 1, 1);
    pix(319, 239, 1, 1);
    rect(10, 20, 4, 8);
    pix(319, 239, 0, 1);
    idle(25);
    // reset during DIV_X at E5
    rect(30, 40, 6, 6);
    pix(319, 239, 0, 1);
    idle(4);
    reset = 1;
    @(posedge clk); #1;
    reset = 0;
    sbq.delete(); px.delete(); py.delete(); last_acc = -1000;
    chk_zero("mid_div_reset");
    idle(30);
    chk_zero("after_reset_idle");
    rect(150, 120, 8, 9);
    pix(319, 239, 0, 1);
    idle(25);
    // randomized frames with random gaps
    for (int f = 0; f < 10; f++) begin
      rand_frame();
      idle($urandom_range(0, 30));
    end
    w = 0;
    while (sbq.size() > 0 && w < 60) begin
      @(negedge clk); #1;
      w++;
    end
    chk("pending_results", sbq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
